// File: rtl/bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_if
// Description : Requester-side and memory-side signals of the bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arb_if #(
    parameter int NUM_DOMAINS = 2,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8
);
    logic [NUM_DOMAINS-1:0]        req;
    logic [NUM_DOMAINS-1:0]        we;
    logic [NUM_DOMAINS*ADDR_W-1:0] addr;
    logic [NUM_DOMAINS*DATA_W-1:0] wdata;
    logic [NUM_DOMAINS-1:0]        pc_inhibit;
    logic [NUM_DOMAINS-1:0]        done;
    logic                          err;
    logic [DATA_W-1:0]             bus_in;
    logic                          mem_req;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic                          mem_ack;
    logic [DATA_W-1:0]             mem_rdata;

    // The arbiter itself.
    modport slave (
        input  req, we, addr, wdata, mem_ack, mem_rdata,
        output pc_inhibit, done, err, bus_in, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Requesting domains and memory model.
    modport master (
        output req, we, addr, wdata, mem_ack, mem_rdata,
        input  pc_inhibit, done, err, bus_in, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb
// Description : Round-robin bus arbiter and req/ack memory-port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb #(
    parameter int NUM_DOMAINS = 2,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic      clk,
    input  logic      reset,
    bus_arb_if.slave  bus
);
    localparam int GW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_DOMAINS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   bus_in_q, bus_in_d;

    logic [GW-1:0]          win;
    logic                   win_vld;
    logic [GW-1:0]          idx;
    logic [NUM_DOMAINS-1:0] done_w;

    // First requester found scanning upward from the domain after last_grant.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_DOMAINS; k++) begin
            idx = GW'((int'(last_q) + k) % NUM_DOMAINS);
            if (!win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_in_d    = bus_in_q;
        case (state_q)
            S_IDLE: begin
                mem_req_d = 1'b0;
                if (win_vld) begin
                    grant_d     = win;
                    mem_we_d    = bus.we[win];
                    mem_addr_d  = bus.addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.wdata[int'(win)*DATA_W +: DATA_W];
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) bus_in_d = bus.mem_rdata;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: this is the TIMEOUT-th cycle without an ack.
                    mem_req_d = 1'b0;
                    bus_in_d  = '1;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_in_q    <= bus_in_d;
        end
    end

    always_comb begin
        done_w = '0;
        if (state_q == S_DONE) done_w[grant_q] = 1'b1;
    end

    assign bus.done       = done_w;
    assign bus.err        = (state_q == S_DONE) && err_q;
    assign bus.pc_inhibit = bus.req & ~done_w;
    assign bus.bus_in     = bus_in_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
`default_nettype wire
